// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the data RAM responder: FSM encoding, wait-counter
// width, byte-lane count and a small byte-enable helper.
package data_ram_responder_pkg;

    localparam int WAIT_CNT_W = 4;
    localparam int NUM_LANES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte enables arrive active-low; storage wants active-high lane writes.
    function automatic logic [NUM_LANES-1:0] lane_write_mask(input logic [NUM_LANES-1:0] be_n);
        return ~be_n;
    endfunction

endpackage

// File: rtl/data_ram_responder_byte_lane_ram.sv
// Word-organised storage split into independent byte lanes so each lane can
// be written on its own. Both write and read are synchronous; contents are
// never reset.
module byte_lane_ram
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                            clk,
    input  logic                            wr_en,
    input  logic [NUM_LANES-1:0]            wr_lane_en,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [31:0]                     wr_data,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    output logic [31:0]                     rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [7:0] mem [0:DEPTH-1];
            logic [7:0] rd_q;

            // Per-lane write port plus registered read of the same lane.
            always_ff @(posedge clk) begin
                if (wr_en && wr_lane_en[gi]) begin
                    mem[wr_addr] <= wr_data[8*gi +: 8];
                end
                rd_q <= mem[rd_addr];
            end

            assign rd_data[8*gi +: 8] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/data_ram_responder.sv
// Asynchronous-SRAM-style slave in front of a byte-lane RAM. A request is
// latched in IDLE, optionally held for a number of wait states, then
// completed in RESP with a one-cycle ram_ready pulse. Out-of-range requests
// complete normally but flag access_err; requests with both strobes low are
// rejected with access_err alone.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ram_ce_n,
    input  logic                 ram_we_n,
    input  logic                 ram_oe_n,
    input  logic [NUM_LANES-1:0] ram_byte_en_n,
    input  logic [31:0]          ram_addr,
    inout  wire logic [31:0]     ram_data,
    output logic                 ram_ready,
    output logic                 access_err
);

    // Counter preload; WAIT_CYCLES=0 skips WAIT entirely so the value is moot.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    // Request decode on the live bus.
    logic [31:0]           offset;
    logic                  req_valid;
    logic                  req_illegal;
    logic                  req_in_range;
    logic [ADDR_WIDTH-1:0] req_idx;

    assign offset       = ram_addr - BASE_ADDR;
    assign req_valid    = !ram_ce_n && (ram_we_n != ram_oe_n);
    assign req_illegal  = !ram_ce_n && !ram_we_n && !ram_oe_n;
    assign req_in_range = (offset >> (ADDR_WIDTH + 2)) == 32'd0;
    assign req_idx      = offset[ADDR_WIDTH+1:2];

    // Latched access and registered outputs.
    state_t                  state_reg;
    logic [WAIT_CNT_W-1:0]   cnt_reg;
    logic [ADDR_WIDTH-1:0]   idx_reg;
    logic [NUM_LANES-1:0]    be_n_reg;
    logic [31:0]             wdata_reg;
    logic                    write_reg;
    logic                    in_range_reg;
    logic [31:0]             rd_reg;
    logic                    drive_en_reg;
    logic                    ready_reg;
    logic                    err_reg;

    // Storage interface.
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [31:0]           mem_rd_data;

    // The write commits on the edge that leaves RESP, unless reset cancels it.
    assign mem_wr_en = rst_n && (state_reg == ST_RESP) && write_reg && in_range_reg;

    // In IDLE the RAM looks up the incoming address so the word is ready even
    // with zero wait states; afterwards it keeps re-reading the latched word.
    assign mem_rd_addr = (state_reg == ST_IDLE) ? req_idx : idx_reg;

    byte_lane_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk        (clk),
        .wr_en      (mem_wr_en),
        .wr_lane_en (lane_write_mask(be_n_reg)),
        .wr_addr    (idx_reg),
        .wr_data    (wdata_reg),
        .rd_addr    (mem_rd_addr),
        .rd_data    (mem_rd_data)
    );

    // Access sequencer: accept, wait, respond; pulses are cleared every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            rd_reg       <= '0;
            drive_en_reg <= 1'b0;
            ready_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            if (ram_ce_n || ram_oe_n) begin
                drive_en_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (req_illegal) begin
                        err_reg <= 1'b1;
                    end else if (req_valid) begin
                        idx_reg      <= req_idx;
                        be_n_reg     <= ram_byte_en_n;
                        wdata_reg    <= ram_data;
                        write_reg    <= !ram_we_n;
                        in_range_reg <= req_in_range;
                        if (WAIT_CYCLES == 0) begin
                            state_reg <= ST_RESP;
                        end else begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= WAIT_LOAD;
                        end
                    end
                end

                ST_WAIT: begin
                    if (ram_ce_n) begin
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg == '0) begin
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                ST_RESP: begin
                    ready_reg <= 1'b1;
                    err_reg   <= !in_range_reg;
                    if (!write_reg) begin
                        rd_reg       <= in_range_reg ? mem_rd_data : 32'h0;
                        drive_en_reg <= !ram_ce_n && !ram_oe_n;
                    end
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_ready  = ready_reg;
    assign access_err = err_reg;

    // Drive read data only while a completed read is still being strobed.
    assign ram_data = (rst_n && drive_en_reg && !ram_ce_n && !ram_oe_n && ram_we_n)
                      ? rd_reg : {32{1'bz}};

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed and randomized checks of data_ram_responder against a word-level
// memory model. The shared data bus has a pull-up, so a released bus reads
// as all ones.
module tb_data_ram_responder;

    localparam int          AW   = 10;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int          WC   = 1;
    localparam int          WORDS = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce_n = 1'b1;
    logic        we_n = 1'b1;
    logic        oe_n = 1'b1;
    logic [3:0]  be_n = 4'hF;
    logic [31:0] addr = 32'h0;
    logic        tb_drive = 1'b0;
    logic [31:0] tb_wdata = 32'h0;
    wire  [31:0] ram_data;
    wire         ram_ready;
    wire         access_err;

    pullup (ram_data);
    assign ram_data = tb_drive ? tb_wdata : {32{1'bz}};

    always #5 clk = ~clk;

    data_ram_responder #(
        .ADDR_WIDTH  (AW),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ram_ce_n      (ce_n),
        .ram_we_n      (we_n),
        .ram_oe_n      (oe_n),
        .ram_byte_en_n (be_n),
        .ram_addr      (addr),
        .ram_data      (ram_data),
        .ram_ready     (ram_ready),
        .access_err    (access_err)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem   [0:WORDS-1];
    bit          model_valid [0:WORDS-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(4 * WORDS);
    endfunction

    function automatic int model_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off / 4);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        int w;
        if (model_in_range(a)) begin
            w = model_word(a);
            for (int l = 0; l < 4; l++) begin
                if (!be[l]) model_mem[w][8*l +: 8] = d[8*l +: 8];
            end
            if (be == 4'b0000) model_valid[w] = 1'b1;
        end
    endtask

    // One complete access, started just after a rising edge. Checks latency,
    // error flag, read data against the model and bus release afterwards.
    task automatic access(input bit wr, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d, input string tag);
        int          lat;
        bit          seen;
        logic        err;
        logic [31:0] rdata;
        lat = 99; seen = 0; err = 1'bx; rdata = 32'hxxxx_xxxx;
        ce_n = 1'b0; we_n = !wr; oe_n = wr; be_n = be; addr = a;
        tb_drive = wr; tb_wdata = d;
        for (int k = 1; k <= 12 && !seen; k++) begin
            @(posedge clk); #1;
            if (ram_ready === 1'b1) begin
                seen = 1; lat = k - 1; err = access_err; rdata = ram_data;
            end
        end
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; tb_drive = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(WC + 1));
        check({tag, " access_err"}, {31'd0, err}, {31'd0, !model_in_range(a)});
        if (wr) begin
            model_write(a, be, d);
        end else if (!model_in_range(a)) begin
            check({tag, " oor rdata"}, rdata, 32'h0);
        end else if (model_valid[model_word(a)]) begin
            check({tag, " rdata"}, rdata, model_mem[model_word(a)]);
        end
        #1;
        check({tag, " bus released"}, ram_data, 32'hFFFF_FFFF);
        $display("%s %s addr=%h be_n=%b wdata=%h rdata=%h lat=%0d err=%b",
                 tag, wr ? "WR" : "RD", a, be, d, rdata, lat, err);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          cnt;
        bit          wr;
        logic [31:0] a;
        logic [3:0]  be;

        for (int i = 0; i < WORDS; i++) begin
            model_mem[i] = 32'h0;
            model_valid[i] = 1'b0;
        end

        // Reset with a read strobe present: nothing may be driven or pulsed.
        rst_n = 1'b0; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = BASE;
        repeat (3) @(posedge clk);
        #1;
        check("reset ram_ready", {31'd0, ram_ready}, 32'd0);
        check("reset access_err", {31'd0, access_err}, 32'd0);
        check("reset bus z", ram_data, 32'hFFFF_FFFF);
        ce_n = 1'b1; oe_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset done");

        // Full write then read, then partial-lane and no-lane writes.
        access(1, BASE + 32'h10, 4'b0000, 32'hDEAD_BEEF, "wr_full");
        access(0, BASE + 32'h10, 4'b0000, 32'h0, "rd_full");
        access(1, BASE + 32'h10, 4'b1010, 32'h1122_3344, "wr_lanes");
        access(0, BASE + 32'h13, 4'b1111, 32'h0, "rd_lanes");
        check("lane merge value", model_mem[4], 32'hDE22_BE44);
        access(1, BASE + 32'h10, 4'b1111, 32'h5555_5555, "wr_nolanes");
        access(0, BASE + 32'h10, 4'b0000, 32'h0, "rd_nolanes");

        // Out-of-range read and write; word 0 must be untouched.
        access(1, BASE, 4'b0000, 32'h0BAD_F00D, "wr_word0");
        access(0, BASE + 32'd4096, 4'b0000, 32'h0, "rd_oor");
        access(1, BASE + 32'd4096, 4'b0000, 32'hAAAA_AAAA, "wr_oor");
        access(0, BASE - 32'd4, 4'b0000, 32'h0, "rd_below_base");
        access(0, BASE, 4'b0000, 32'h0, "rd_word0");

        // Chip enable dropped during WAIT aborts the write.
        access(1, BASE + 32'h20, 4'b0000, 32'h1234_5678, "wr_pre_abort");
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; be_n = 4'b0000; addr = BASE + 32'h20;
        tb_drive = 1'b1; tb_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        ce_n = 1'b1; we_n = 1'b1; tb_drive = 1'b0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (ram_ready === 1'b1) cnt++;
        end
        check("abort no ready", 32'(cnt), 32'd0);
        $display("abort ready_pulses=%0d", cnt);
        access(0, BASE + 32'h20, 4'b0000, 32'h0, "rd_after_abort");

        // Both strobes low: error one cycle later, no ready, bus stays released.
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; addr = BASE + 32'h10;
        #1;
        check("illegal bus z during", ram_data, 32'hFFFF_FFFF);
        check("illegal err not early", {31'd0, access_err}, 32'd0);
        @(posedge clk); #1;
        check("illegal access_err", {31'd0, access_err}, 32'd1);
        check("illegal no ready", {31'd0, ram_ready}, 32'd0);
        check("illegal bus z", ram_data, 32'hFFFF_FFFF);
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
        @(posedge clk); #1;
        check("illegal err one cycle", {31'd0, access_err}, 32'd0);
        check("illegal still no ready", {31'd0, ram_ready}, 32'd0);
        $display("illegal request done");
        access(0, BASE + 32'h10, 4'b0000, 32'h0, "rd_after_illegal");

        // Held write request: re-accepted after each completion, one-cycle pulses.
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; be_n = 4'b0000; addr = BASE + 32'h40;
        tb_drive = 1'b1; tb_wdata = 32'hA5A5_5A5A;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ram_ready === 1'b1) cnt++;
        end
        ce_n = 1'b1; we_n = 1'b1; tb_drive = 1'b0;
        check("back-to-back pulses", 32'(cnt), 32'd2);
        $display("back-to-back ready_pulses=%0d", cnt);
        model_write(BASE + 32'h40, 4'b0000, 32'hA5A5_5A5A);
        repeat (2) @(posedge clk);
        #1;
        access(0, BASE + 32'h40, 4'b0000, 32'h0, "rd_b2b");

        // Reset during RESP of a read cancels it; storage survives.
        access(1, BASE + 32'h30, 4'b0000, 32'hCAFE_0001, "wr_pre_reset");
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = BASE + 32'h30;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("resp no ready yet", {31'd0, ram_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("reset in resp ready", {31'd0, ram_ready}, 32'd0);
        check("reset in resp bus z", ram_data, 32'hFFFF_FFFF);
        ce_n = 1'b1; oe_n = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset during RESP done");
        access(0, BASE + 32'h30, 4'b0000, 32'h0, "rd_after_reset");

        // Randomized traffic over a small word pool plus occasional out-of-range.
        for (int k = 0; k < 16; k++) begin
            access(1, BASE + 32'h400 + 32'(4 * k), 4'b0000, $urandom, "rnd_fill");
        end
        for (int n = 0; n < 40; n++) begin
            wr = $urandom_range(0, 1) == 1;
            be = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0)
                a = BASE + 32'd4096 + 32'($urandom_range(0, 4000));
            else
                a = BASE + 32'h400 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            access(wr, a, be, $urandom, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: word-address bits; storage depth is 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 Parameter WAIT_CYCLES, default 1, legal range 0..15: wait states inserted before the response cycle.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 ram_ce_n  input  1  chip enable, active-low.
REQ-007 ram_we_n  input  1  write strobe, active-low.
REQ-008 ram_oe_n  input  1  output enable (read), active-low.
REQ-009 ram_byte_en_n  input  4  byte-lane enables, active-low; bit i selects data[8i+7:8i].
REQ-010 ram_addr  input  32  byte address.
REQ-011 ram_data  inout  32  write data in; read data driven out, otherwise high-Z.
REQ-012 ram_ready  output  1  one-cycle pulse marking completion of an accepted access.
REQ-013 access_err  output  1  one-cycle pulse on an out-of-range or illegal request.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP.
- Request: ram_ce_n=0 with exactly one of ram_we_n/ram_oe_n low.
- Offset: ram_addr-BASE_ADDR.
- Word index: offset[ADDR_WIDTH+1:2].
- In range: offset < 4*2^ADDR_WIDTH.
REQ-015 IDLE SHALL accept a request by latching word index, byte enables, ram_data (writes) and direction. It SHALL go to WAIT with counter=WAIT_CYCLES-1, or to RESP when WAIT_CYCLES=0.
REQ-016 WAIT SHALL decrement the counter and go to RESP on the cycle the counter is 0.
REQ-017 If ram_ce_n rises during WAIT, the FSM SHALL abort to IDLE: no write, no ram_ready.
REQ-018 RESP SHALL assert ram_ready for exactly one cycle and return to IDLE.
- Latency: ram_ready asserts WAIT_CYCLES+1 cycles after the accepting edge.
REQ-019 A write in RESP SHALL update only the lanes whose latched byte_en_n bit is 0. All four bits high SHALL complete the access with no storage change.
REQ-020 A read SHALL load the full addressed word into a read register in RESP, ignoring byte enables.
- ram_data is driven from that register from the cycle after RESP until ram_ce_n or ram_oe_n goes high.
REQ-021 ram_data SHALL be high-Z whenever ram_ce_n=1, ram_oe_n=1 or ram_we_n=0, and during reset.
REQ-022 Out-of-range request:
- Completes with normal timing and ram_ready.
- Reads return 32'h0; writes are ignored.
- access_err pulses in the same cycle as ram_ready.
REQ-023 ram_ce_n=0 with both ram_we_n and ram_oe_n low SHALL be illegal.
- No storage change, no ram_ready.
- access_err pulses one cycle later; the FSM stays in IDLE.
REQ-024 A request still present in IDLE after RESP SHALL be accepted as a new access. Back-to-back identical writes are idempotent.
REQ-025 Word index arithmetic SHALL be unsigned modulo 2^32. The low two address bits SHALL be ignored.

Reset
REQ-026 While rst_n=0 at a clock edge:
- FSM -> IDLE, counter -> 0.
- ram_ready=0, access_err=0, read register=0, ram_data high-Z.
REQ-027 Reset mid-access SHALL cancel the access without a write. Storage contents SHALL NOT be reset.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the wait-counter width (4) and the byte-lane count (4).
REQ-029 Storage SHALL be one sub-module, byte_lane_ram: 2^ADDR_WIDTH x 32 with a synchronous per-lane write and a synchronous read.

Verification
REQ-030 WAIT_CYCLES=1: write 32'hDEAD_BEEF to 0x10 with byte_en_n=4'b0000, then read 0x10 -> ram_ready 2 cycles after each accept; read returns 32'hDEAD_BEEF.
REQ-031 Write 32'h1122_3344 with byte_en_n=4'b1010 over 32'hDEAD_BEEF at 0x10, then read -> 32'hDE22_BE44.
REQ-032 Read at BASE_ADDR+4096 (ADDR_WIDTH=10) -> data 32'h0, ram_ready and access_err pulse together. A write at 4096 leaves word 0 unchanged.
REQ-033 ram_ce_n raised during WAIT (WAIT_CYCLES=3) of a write of 32'hFFFF_FFFF to 0x20 -> no ram_ready, word at 0x20 unchanged.
REQ-034 ram_we_n and ram_oe_n both low with ram_ce_n low -> access_err pulse, no ram_ready, ram_data stays high-Z.
REQ-035 rst_n low during RESP of a read -> ram_ready=0 and ram_data high-Z next cycle; a prior write of 32'hCAFE_0001 survives and reads back after reset.
